// File: rtl/ysyx_22040125_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, bus response codes.
package ysyx_22040125_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_RADDR = 3'd1;
    localparam state_t ST_RDATA = 3'd2;
    localparam state_t ST_WREQ  = 3'd3;
    localparam state_t ST_WRESP = 3'd4;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic [3:0] size_to_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/ysyx_22040125_lsu_align.sv
// Combinational lane logic: store strobes and lane replication, load shift and sign/zero extension.
module ysyx_22040125_lsu_align
    import ysyx_22040125_lsu_pkg::*;
#(
    parameter int  XLEN   = 64,
    localparam int STRB_W = XLEN / 8,
    localparam int OFF_W  = $clog2(STRB_W)
) (
    input  logic [1:0]        size_i,
    input  logic [OFF_W-1:0]  offset_i,
    input  logic              unsigned_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic [XLEN-1:0]   wdata_o,
    output logic [STRB_W-1:0] strb_o,
    output logic [XLEN-1:0]   rdata_o
);

    logic [3:0]      nbytes;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            sign;

    always_comb begin
        nbytes  = size_to_bytes(size_i);
        strb_o  = STRB_W'((16'd1 << nbytes) - 16'd1) << offset_i;
        shifted = rdata_i >> {offset_i, 3'b000};
        wdata_o = '0;
        mask    = '0;
        sign    = 1'b0;
        for (int i = 0; i < STRB_W; i++) begin
            // Each lane carries the byte the store would place there if aligned to it.
            wdata_o[i*8 +: 8] = wdata_i[(i % int'(nbytes))*8 +: 8];
            mask[i*8 +: 8]    = (i < int'(nbytes)) ? 8'hFF : 8'h00;
            if (i == int'(nbytes) - 1) begin
                sign = shifted[i*8 + 7];
            end
        end
        sign    = sign & ~unsigned_i;
        rdata_o = (shifted & mask) | ({XLEN{sign}} & ~mask);
    end

endmodule

// File: rtl/ysyx_22040125_lsu.sv
// Multi-cycle load/store unit on split AR/R and AW/W/B channels; stalls the pipeline until the response returns.
// Define YSYX_22040125_LSU_MISALIGN_TRAP_EN to reject misaligned accesses with an error instead of aligning them down.
module ysyx_22040125_lsu
    import ysyx_22040125_lsu_pkg::*;
#(
    parameter int  XLEN   = 64,
    parameter int  ADDR_W = 32,
    localparam int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              stall_mem,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ADDR_W-1:0] ar_addr,
    output logic [2:0]        ar_size,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [XLEN-1:0]   r_data,
    input  logic [1:0]        r_resp,
    output logic              aw_valid,
    input  logic              aw_ready,
    output logic [ADDR_W-1:0] aw_addr,
    output logic [2:0]        aw_size,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [XLEN-1:0]   w_data,
    output logic [STRB_W-1:0] w_strb,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [1:0]        b_resp
);

    localparam int OFF_W = $clog2(STRB_W);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic [XLEN-1:0]     wdata_q;
    logic [STRB_W-1:0]   strb_q;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]     resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;

    logic                idle;
    logic                req_go;
    logic [OFF_W-1:0]    low_mask;
    logic [OFF_W-1:0]    req_off;
    logic [1:0]          al_size;
    logic [OFF_W-1:0]    al_off;
    logic [XLEN-1:0]     al_wdata;
    logic [STRB_W-1:0]   al_strb;
    logic [XLEN-1:0]     al_rdata;

    assign idle     = (state_q == ST_IDLE);
    assign low_mask = OFF_W'(size_to_bytes(req_size) - 4'd1);
    assign req_off  = req_addr[OFF_W-1:0] & ~low_mask;

`ifdef YSYX_22040125_LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = |(req_addr[OFF_W-1:0] & low_mask);
    assign req_go     = req_valid && idle && !misaligned;
`else
    assign req_go     = req_valid && idle;
`endif

    // The aligner serves the incoming store while idle and the in-flight load otherwise.
    assign al_size = idle ? req_size : size_q;
    assign al_off  = idle ? req_off  : addr_q[OFF_W-1:0];

    ysyx_22040125_lsu_align #(.XLEN(XLEN)) u_align (
        .size_i     (al_size),
        .offset_i   (al_off),
        .unsigned_i (uns_q),
        .wdata_i    (req_wdata),
        .rdata_i    (r_data),
        .wdata_o    (al_wdata),
        .strb_o     (al_strb),
        .rdata_o    (al_rdata)
    );

    always_comb begin
        state_d      = state_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_go) begin
                    state_d   = req_we ? ST_WREQ : ST_RADDR;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
`ifdef YSYX_22040125_LSU_MISALIGN_TRAP_EN
                else if (req_valid) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end
`endif
            end
            ST_RADDR: if (ar_ready) state_d = ST_RDATA;
            ST_RDATA: begin
                if (r_valid) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = al_rdata;
                    resp_err_d   = (r_resp != RESP_OKAY);
                end
            end
            ST_WREQ: begin
                if (aw_ready) aw_done_d = 1'b1;
                if (w_ready)  w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = ST_WRESP;
            end
            ST_WRESP: begin
                if (b_valid) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b1;
                    resp_err_d   = (b_resp != RESP_OKAY);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            strb_q       <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            if (req_go) begin
                addr_q  <= {req_addr[ADDR_W-1:OFF_W], req_off};
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                wdata_q <= al_wdata;
                strb_q  <= al_strb;
            end
        end
    end

    assign req_ready  = idle;
    assign stall_mem  = (req_valid && !req_ready) || !idle;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    assign ar_valid = (state_q == ST_RADDR);
    assign ar_addr  = addr_q;
    assign ar_size  = {1'b0, size_q};
    assign r_ready  = (state_q == ST_RDATA);
    assign aw_valid = (state_q == ST_WREQ) && !aw_done_q;
    assign aw_addr  = addr_q;
    assign aw_size  = {1'b0, size_q};
    assign w_valid  = (state_q == ST_WREQ) && !w_done_q;
    assign w_data   = wdata_q;
    assign w_strb   = strb_q;
    assign b_ready  = (state_q == ST_WRESP);

endmodule

// File: doc/ysyx_22040125_lsu.md
# ysyx_22040125_lsu

Parametrised load/store unit replacing the combinational memory stage. It accepts one load or store per request handshake from the pipeline and runs it as a multi-cycle transaction on separate read (AR/R) and write (AW/W/B) channels. It aligns write data and strobes, extracts and extends read data by address offset, detects misaligned accesses, and holds the pipeline stall until the response returns.

## Interface
Parameters:
- XLEN, 64, data width; 32 or 64.
- ADDR_W, 32, address width.
- STRB_W, XLEN/8, derived byte-strobe width; not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  pipeline request valid.
- req_ready  out  1  LSU can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 double (double legal only when XLEN=64).
- req_unsigned  in  1  zero-extend the load result; ignored for stores.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores.
- resp_err  out  1  bus error or misaligned access, valid with resp_valid.
- stall_mem  out  1  request pending or in flight.
- ar_valid / ar_ready  out / in  1  read address handshake.
- ar_addr  out  ADDR_W  read address.
- ar_size  out  3  log2 bytes.
- r_valid / r_ready  in / out  1  read data handshake.
- r_data  in  XLEN  read data.
- r_resp  in  2  read response; nonzero = error.
- aw_valid / aw_ready  out / in  1  write address handshake.
- aw_addr  out  ADDR_W  write address.
- aw_size  out  3  log2 bytes.
- w_valid / w_ready  out / in  1  write data handshake.
- w_data  out  XLEN  write data.
- w_strb  out  STRB_W  write strobes.
- b_valid / b_ready  in / out  1  write response handshake.
- b_resp  in  2  write response; nonzero = error.

## Operation
- States: IDLE, RADDR, RDATA, WREQ, WRESP.
- IDLE: req_ready=1. Accept on req_valid&&req_ready. Register addr, size, unsigned, aligned wdata and strobes. Loads go to RADDR; stores go to WREQ.
- RADDR: ar_valid=1 until ar_ready, then RDATA.
- RDATA: r_ready=1. On r_valid: shift r_data right by offset×8, sign- or zero-extend to XLEN, go to IDLE.
- WREQ: aw_valid and w_valid assert together. Each drops independently after its own handshake. When both are done, go to WRESP.
- WRESP: b_ready=1. On b_valid, go to IDLE.
- Offset = addr[log2(STRB_W)-1:0].
- w_data = wdata replicated across lanes.
- w_strb = ((1<<(1<<size))-1) << offset.
- Bus address and size are driven with the full byte address. The registered value is held stable while valid is high.
- resp_err = |r_resp or |b_resp.
- stall_mem = req_valid&&!req_ready, or state != IDLE.
- Reset in any state: state IDLE, all handshake outputs 0, resp_valid 0, resp_rdata 0, resp_err 0, stored request discarded.

## Timing
- Request accepted in cycle N. ar_valid or aw_valid/w_valid is high from N+1.
- resp_valid is registered: it pulses in the cycle after the R or B handshake. In that same cycle the state is IDLE and req_ready=1, so back-to-back requests are allowed.
- Minimum load latency with zero-wait bus: accept N, AR N+1, R N+2, resp N+3.
- AW and W handshakes may complete in the same or different cycles, in either order.
- Valid outputs never drop before their handshake.

## Configuration
- Macro: YSYX_22040125_LSU_MISALIGN_TRAP_EN.
- Defined: an access with offset not a multiple of the access size issues no bus transaction. The state stays IDLE, and resp_valid with resp_err=1 pulses the cycle after accept. resp_rdata is 0.
- Undefined: low offset bits below the access size are cleared before the access, and the access proceeds normally with no error.

## Structure
- Package ysyx_22040125_lsu_pkg holds:
  - size encodings (SZ_B/H/W/D)
  - state enum
  - RESP_OKAY constant
  - function size_to_bytes
- One combinational sub-module, ysyx_22040125_lsu_align, covers:
  - strobe generation
  - write lane replication
  - read shift and extension
- The FSM and registers live in the top level.

## Test plan
- Load byte signed, XLEN=64, addr 0x8000_0003, r_data 0x1122_3344_8566_7788 → resp_rdata 0xFFFF_FFFF_FFFF_FF85, resp_err 0, resp three cycles after accept.
- Store half, addr 0x8000_0006, wdata 0xABCD → w_strb 0xC0, w_data bits[63:48] = 0xABCD; aw_ready delayed 3 cycles relative to w_ready → single B wait, one resp_valid pulse.
- Load word unsigned with r_resp=2'b10 → resp_err 1, resp_rdata 0x0000_0000_xxxx_xxxx zero-extended, FSM returns IDLE.
- Misaligned word load at addr 0x…2, macro defined → no ar_valid, resp_err 1 next cycle. Macro undefined → ar_addr 0x…0, resp_err 0.
- rst_n asserted low during RDATA → all outputs 0 immediately. After release, a new request is accepted with no stale resp_valid.
- Back-to-back store then load, zero-wait bus → second request accepted in the resp_valid cycle of the first, no idle gap.
